// File: rtl/despachador_divisor_if.sv
// Handshake bundle for the divider issue stage: input pair stream, divider
// START/DONE side and result stream. The slave modport is the dispatcher's view.
interface despachador_divisor_if #(
  parameter int SIZE  = 32,
  parameter int DEPTH = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic [SIZE-1:0]              in_num;
  logic [SIZE-1:0]              in_den;

  logic                         div_rst_n;
  logic                         div_start;
  logic [SIZE-1:0]              div_num;
  logic [SIZE-1:0]              div_den;
  logic [SIZE-1:0]              div_coc;
  logic [SIZE-1:0]              div_res;
  logic                         div_done;

  logic                         out_valid;
  logic                         out_ready;
  logic [SIZE-1:0]              out_coc;
  logic [SIZE-1:0]              out_res;
  logic                         out_divzero;

  logic [$clog2(DEPTH+1)-1:0]   count;

  modport slave (
    input  in_valid, in_num, in_den,
    input  div_coc, div_res, div_done,
    input  out_ready,
    output in_ready,
    output div_rst_n, div_start, div_num, div_den,
    output out_valid, out_coc, out_res, out_divzero,
    output count
  );

  modport master (
    output in_valid, in_num, in_den,
    output div_coc, div_res, div_done,
    output out_ready,
    input  in_ready,
    input  div_rst_n, div_start, div_num, div_den,
    input  out_valid, out_coc, out_res, out_divzero,
    input  count
  );
endinterface

// File: rtl/despachador_divisor.sv
// Issue stage for divisor_top: in-order FIFO of num/den pairs, one operation in
// flight, den==0 answered locally without touching the divider.
module despachador_divisor #(
  parameter int SIZE  = 32,
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  despachador_divisor_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [SIZE-1:0] num;
    logic [SIZE-1:0] den;
  } req_t;

  typedef struct packed {
    logic [SIZE-1:0] coc;
    logic [SIZE-1:0] res;
    logic            divzero;
  } rsp_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t        state, state_nx;
  req_t          fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  req_t          head, op_q;
  rsp_t          rsp_q;
  logic          out_vld;
  logic          full, push, pop, head_dz;
  logic          load_div, load_dz, load_done, release_out;

  assign full    = (cnt == CW'(DEPTH));
  assign push    = bus.in_valid && !full;
  assign head    = fifo_q[rd_ptr];
  assign head_dz = (head.den == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= {bus.in_num, bus.in_den};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // DONE only matters in WAIT; a stray pulse anywhere else is dropped.
  always_comb begin
    state_nx    = state;
    pop         = 1'b0;
    load_div    = 1'b0;
    load_dz     = 1'b0;
    load_done   = 1'b0;
    release_out = 1'b0;
    unique case (state)
      IDLE: begin
        if (cnt != '0) begin
          pop = 1'b1;
          if (head_dz) begin
            load_dz  = 1'b1;
            state_nx = HOLD;
          end else begin
            load_div = 1'b1;
            state_nx = ISSUE;
          end
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (bus.div_done) begin
          load_done = 1'b1;
          state_nx  = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          release_out = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      rsp_q   <= '0;
      out_vld <= 1'b0;
    end else begin
      if (load_div) op_q <= head;
      if (load_dz) begin
        rsp_q   <= {{SIZE{1'b1}}, head.num, 1'b1};
        out_vld <= 1'b1;
      end else if (load_done) begin
        rsp_q   <= {bus.div_coc, bus.div_res, 1'b0};
        out_vld <= 1'b1;
      end else if (release_out) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = !full;
  assign bus.count       = cnt;
  assign bus.div_rst_n   = ~rst;
  assign bus.div_start   = (state == ISSUE);
  assign bus.div_num     = op_q.num;
  assign bus.div_den     = op_q.den;
  assign bus.out_valid   = out_vld;
  assign bus.out_coc     = rsp_q.coc;
  assign bus.out_res     = rsp_q.res;
  assign bus.out_divzero = rsp_q.divzero;

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt <= CW'(DEPTH));
  a_start_pulse: assert property (@(posedge clk) disable iff (rst) (state == ISSUE) |=> (state == WAIT));
endmodule

// File: tb/tb_despachador_divisor.sv
// Bench for despachador_divisor: constant vector table, hand sequences for the
// capacity/reset/stray-DONE corners and a randomized run against a queue model.
module tb_despachador_divisor;
  localparam int SIZE  = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] coc;
    logic [31:0] res;
    logic        dz;
  } vec_t;

  typedef struct packed {
    logic [31:0] coc;
    logic [31:0] res;
    logic        dz;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  despachador_divisor_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus();
  despachador_divisor #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;
  int   n_start = 0;
  rsp_t exp_q[$];
  rsp_t got_q[$];

  logic        auto_div, mdl_done, man_done, rand_rdy, rr, man_ready;
  logic [31:0] mdl_coc, mdl_res, man_coc, man_res;

  assign bus.div_done  = auto_div ? mdl_done : man_done;
  assign bus.div_coc   = auto_div ? mdl_coc  : man_coc;
  assign bus.div_res   = auto_div ? mdl_res  : man_res;
  assign bus.out_ready = rand_rdy ? rr       : man_ready;

  function automatic rsp_t ref_div(logic [31:0] n, logic [31:0] d);
    rsp_t r;
    if (d == 0) r = '{coc: 32'hFFFF_FFFF, res: n, dz: 1'b1};
    else        r = '{coc: n / d, res: n % d, dz: 1'b0};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns aligned just after the edge that accepted the pair.
  task automatic push(input logic [31:0] n, input logic [31:0] d);
    int  t = 0;
    logic ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_num   = n;
    bus.in_den   = d;
    while (!ok && t < 500) begin
      @(negedge clk);
      ok = bus.in_ready;
      if (!ok) step();
      t++;
    end
    chk("push_accept", ok, 1'b1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int target, input string name);
    int t = 0;
    while (n_out < target && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(name, n_out >= target, 1'b1);
    step();
  endtask

  // Divider model: answers each START after a random latency.
  initial begin
    logic [31:0] n, d;
    int lat;
    mdl_done = 1'b0;
    mdl_coc  = '0;
    mdl_res  = '0;
    forever begin
      @(negedge clk);
      if (bus.div_start && auto_div && !rst) begin
        n = bus.div_num;
        d = bus.div_den;
        chk("start_den_nonzero", d != 0, 1'b1);
        lat = $urandom_range(1, 4);
        repeat (lat) begin
          step();
          chk("div_num_stable", bus.div_num, n);
          chk("div_den_stable", bus.div_den, d);
        end
        mdl_done = 1'b1;
        mdl_coc  = (d != 0) ? n / d : '0;
        mdl_res  = (d != 0) ? n % d : '0;
        step();
        mdl_done = 1'b0;
      end
    end
  end

  initial begin
    rr = 1'b1;
    forever begin
      step();
      rr = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard and protocol monitor.
  logic hold_prev = 1'b0;
  logic prev_start = 1'b0;
  rsp_t prev_rsp, sb_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        hold_prev  = 1'b0;
        prev_start = 1'b0;
      end else begin
        if (hold_prev) begin
          chk("hold_valid", bus.out_valid, 1'b1);
          chk("hold_coc_dz", {bus.out_coc, bus.out_divzero}, {prev_rsp.coc, prev_rsp.dz});
          chk("hold_res", bus.out_res, prev_rsp.res);
        end
        if (prev_start) chk("start_width", bus.div_start, 1'b0);
        if (bus.div_start) n_start++;
        prev_start = bus.div_start;
        if (bus.out_valid && bus.out_ready) begin
          chk("sb_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            sb_e = exp_q.pop_front();
            chk("sb_coc", bus.out_coc, sb_e.coc);
            chk("sb_res", bus.out_res, sb_e.res);
            chk("sb_dz", bus.out_divzero, sb_e.dz);
          end
          got_q.push_back('{coc: bus.out_coc, res: bus.out_res, dz: bus.out_divzero});
          n_out++;
        end
        hold_prev = bus.out_valid && !bus.out_ready;
        prev_rsp  = '{coc: bus.out_coc, res: bus.out_res, dz: bus.out_divzero};
        if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_div(bus.in_num, bus.in_den));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    logic acc[6];
    logic ok;
    int   n0, s0, t;
    rsp_t g;

    tbl[0] = '{100,          7, 14,           2, 1'b0};
    tbl[1] = '{5,            0, 32'hFFFFFFFF, 5, 1'b1};
    tbl[2] = '{32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 1'b0};
    tbl[3] = '{7,            9, 0,            7, 1'b0};
    tbl[4] = '{9,            0, 32'hFFFFFFFF, 9, 1'b1};
    tbl[5] = '{1000,        10, 100,          0, 1'b0};
    tbl[6] = '{0,            5, 0,            0, 1'b0};
    tbl[7] = '{0,            0, 32'hFFFFFFFF, 0, 1'b1};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_num   = '0;
    bus.in_den   = '0;
    auto_div  = 1'b1;
    man_done  = 1'b0;
    man_coc   = '0;
    man_res   = '0;
    rand_rdy  = 1'b0;
    man_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_count", bus.count, 0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_div_start", bus.div_start, 1'b0);
    chk("rst_div_operands", {bus.div_num, bus.div_den}, 64'd0);
    chk("rst_out_data", {bus.out_coc, bus.out_res}, 64'd0);
    chk("rst_out_divzero", bus.out_divzero, 1'b0);
    chk("rst_div_rst_n", bus.div_rst_n, 1'b1);
    step();

    // T1 with issue latency
    n0 = n_out; s0 = n_start;
    push(100, 7);
    @(negedge clk);
    chk("t1_no_early_start", bus.div_start, 1'b0);
    step();
    @(negedge clk);
    chk("t1_start_latency", bus.div_start, 1'b1);
    chk("t1_div_operands", {bus.div_num, bus.div_den}, {32'd100, 32'd7});
    step();
    wait_out(n0 + 1, "t1_timeout");
    g = got_q[n0];
    chk("t1_result", {g.coc, g.res}, {32'd14, 32'd2});
    chk("t1_dz", g.dz, 1'b0);
    chk("t1_starts", n_start - s0, 1);

    // T2 divzero bypass with latency
    n0 = n_out; s0 = n_start;
    push(5, 0);
    @(negedge clk);
    chk("t2_not_yet_valid", bus.out_valid, 1'b0);
    step();
    @(negedge clk);
    chk("t2_valid", bus.out_valid, 1'b1);
    chk("t2_data", {bus.out_coc, bus.out_res}, {32'hFFFFFFFF, 32'd5});
    chk("t2_dz", bus.out_divzero, 1'b1);
    step();
    wait_out(n0 + 1, "t2_timeout");
    chk("t2_no_start", n_start - s0, 0);

    // Table vectors, one at a time
    for (int i = 0; i < 8; i++) begin
      n0 = n_out; s0 = n_start;
      push(tbl[i].num, tbl[i].den);
      wait_out(n0 + 1, "tbl_timeout");
      g = got_q[n0];
      chk("tbl_coc", g.coc, tbl[i].coc);
      chk("tbl_res", g.res, tbl[i].res);
      chk("tbl_dz", g.dz, tbl[i].dz);
      chk("tbl_starts", n_start - s0, tbl[i].dz ? 0 : 1);
    end

    // T4 back-to-back stream, in order
    n0 = n_out;
    for (int i = 2; i < 6; i++) push(tbl[i].num, tbl[i].den);
    wait_out(n0 + 4, "t4_timeout");
    for (int i = 0; i < 4; i++) begin
      g = got_q[n0 + i];
      chk("t4_order", {g.coc, g.res, 31'd0, g.dz},
          {tbl[i+2].coc, tbl[i+2].res, 31'd0, tbl[i+2].dz});
    end

    // T3 capacity: DEPTH queued + one held
    man_ready = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_num   = 200 + i * 11;
      bus.in_den   = i + 1;
      @(negedge clk);
      acc[i] = bus.in_ready;
      if (i < 5) step();
    end
    for (int i = 0; i < 6; i++) chk("t3_accept", acc[i], (i < 5) ? 1'b1 : 1'b0);
    repeat (10) step();
    @(negedge clk);
    chk("t3_full_ready", bus.in_ready, 1'b0);
    chk("t3_full_count", bus.count, 4);
    chk("t3_held_valid", bus.out_valid, 1'b1);
    step();
    man_ready = 1'b1;
    ok = 1'b0; t = 0;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = bus.in_ready;
      if (!ok) step();
      t++;
    end
    chk("t3_sixth_accepted", ok, 1'b1);
    step();
    bus.in_valid = 1'b0;
    wait_out(n0 + 6, "t3_timeout");
    g = got_q[n0 + 5];
    chk("t3_last", {g.coc, g.res}, {32'd42, 32'd3});

    // T5 reset during WAIT with entries queued, late DONE ignored
    auto_div = 1'b0;
    n0 = n_out; s0 = n_start;
    push(1000, 3);
    t = 0;
    while (n_start == s0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t5_started", n_start - s0, 1);
    step();
    push(11, 2);
    push(12, 0);
    @(negedge clk);
    chk("t5_queued", bus.count, 2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_out_valid", bus.out_valid, 1'b0);
    chk("t5_count", bus.count, 0);
    chk("t5_in_ready", bus.in_ready, 1'b1);
    step();
    man_done = 1'b1; man_coc = 333; man_res = 1;
    step();
    man_done = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("t5_no_output", n_out - n0, 0);
    chk("t5_no_valid", bus.out_valid, 1'b0);
    chk("t5_no_restart", n_start - s0, 1);
    step();
    auto_div = 1'b1;
    push(8, 2);
    wait_out(n0 + 1, "t5_timeout");
    g = got_q[n0];
    chk("t5_after", {g.coc, g.res, 31'd0, g.dz}, {32'd4, 32'd0, 32'd0});

    // T6 stray DONE in IDLE and HOLD
    auto_div = 1'b0;
    n0 = n_out;
    man_done = 1'b1; man_coc = 123; man_res = 45;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_idle_valid", bus.out_valid, 1'b0);
      step();
    end
    man_done = 1'b0;
    man_ready = 1'b0;
    push(5, 0);
    t = 0;
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("t6_hold_reached", bus.out_valid, 1'b1);
    step();
    man_done = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("t6_hold_data", {bus.out_coc, bus.out_res}, {32'hFFFFFFFF, 32'd5});
    chk("t6_hold_dz", bus.out_divzero, 1'b1);
    step();
    man_done = 1'b0;
    man_ready = 1'b1;
    wait_out(n0 + 1, "t6_timeout");
    repeat (5) step();
    @(negedge clk);
    chk("t6_single_output", n_out - n0, 1);
    chk("t6_idle_after", bus.out_valid, 1'b0);
    step();
    auto_div = 1'b1;

    // Randomized run against the queue model
    rand_rdy = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 80; i++) begin
      logic [31:0] rn, rd;
      rn = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 300);
      case ($urandom_range(0, 7))
        0:       rd = 0;
        1, 2, 3: rd = $urandom_range(1, 20);
        default: rd = $urandom;
      endcase
      push(rn, rd);
      repeat ($urandom_range(0, 2)) step();
    end
    wait_out(n0 + 80, "rand_timeout");
    rand_rdy = 1'b0;
    chk("rand_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
